// File: rtl/tx_arbiter_pkg.sv
// Shared types and sizing helpers for the tx_arbiter block.
package tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } arb_state_t;

    // Gap counter must hold MIN_GAP-1; one spare bit keeps MIN_GAP=1 legal.
    function automatic int gap_cnt_w(input int min_gap);
        return $clog2(min_gap) + 1;
    endfunction

    // Index width for a source number; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_picker
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = 2,
    parameter int IW          = idx_w(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] i_req,
    input  logic [IW-1:0]          i_last,
    output logic [NUM_SOURCES-1:0] o_onehot,
    output logic [IW-1:0]          o_idx,
    output logic                   o_any
);

    logic [IW-1:0] w_cand;

    // Scan sources last+1 .. last+N (mod N); the first one requesting wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            w_cand = IW'((int'(i_last) + k) % NUM_SOURCES);
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one tx byte stream between sources.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int MIN_GAP     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] in_data,
    input  logic [NUM_SOURCES-1:0][2:0]           in_data_bits,
    input  logic [NUM_SOURCES-1:0]                in_data_valid,
    output logic [NUM_SOURCES-1:0]                in_req,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic [2:0]                            out_data_bits,
    output logic                                  out_data_valid,
    input  logic                                  out_req,
    output logic [NUM_SOURCES-1:0]                grant,
    output logic                                  busy
);

    localparam int IW = idx_w(NUM_SOURCES);
    localparam int CW = gap_cnt_w(MIN_GAP);

    arb_state_t             r_state,   w_state_nxt;
    logic [NUM_SOURCES-1:0] r_grant,   w_grant_nxt;
    logic [IW-1:0]          r_gnt_idx, w_gnt_idx_nxt;
    logic [IW-1:0]          r_last,    w_last_nxt;
    logic [CW-1:0]          r_gap_cnt, w_gap_cnt_nxt;

    logic [NUM_SOURCES-1:0] w_pick;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_any;

    rr_picker #(
        .NUM_SOURCES (NUM_SOURCES),
        .IW          (IW)
    ) u_pick (
        .i_req    (in_data_valid),
        .i_last   (r_last),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // State register; reset leaves last_grant at the top so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gnt_idx <= '0;
            r_last    <= IW'(NUM_SOURCES - 1);
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_last    <= w_last_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, watch the owner's valid in ACTIVE, count out GAP.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gnt_idx_nxt = r_gnt_idx;
        w_last_nxt    = r_last;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_grant_nxt   = w_pick;
                    w_gnt_idx_nxt = w_pick_idx;
                    w_last_nxt    = w_pick_idx;
                end
            end
            ST_ACTIVE: begin
                if (!in_data_valid[r_gnt_idx]) begin
                    w_state_nxt   = ST_GAP;
                    w_gap_cnt_nxt = CW'(MIN_GAP - 1);
                    w_grant_nxt   = '0;
                end
            end
            ST_GAP: begin
                // Leave as the count reaches zero so the frame-end cycle, the
                // GAP cycles and the IDLE arbitration cycle total MIN_GAP+1.
                if (r_gap_cnt <= CW'(1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Zero-latency forwarding of the owner's stream; out_req is dropped outside ACTIVE.
    always_comb begin
        out_data       = '0;
        out_data_bits  = '0;
        out_data_valid = 1'b0;
        in_req         = '0;
        if (r_state == ST_ACTIVE) begin
            out_data       = in_data[r_gnt_idx];
            out_data_bits  = in_data_bits[r_gnt_idx];
            out_data_valid = in_data_valid[r_gnt_idx];
            in_req         = r_grant & {NUM_SOURCES{out_req}};
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: producer models, expected-byte queue, gap timing.
module tb_tx_arbiter;

    localparam int MIN_GAP = 4;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] b;
        logic [1:0] g;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][7:0] in_data;
    logic [1:0][2:0] in_data_bits;
    logic [1:0]      in_data_valid;
    logic [1:0]      in_req;
    logic [7:0]      out_data;
    logic [2:0]      out_data_bits;
    logic            out_data_valid;
    logic            out_req;
    logic [1:0]      grant;
    logic            busy;

    tx_arbiter #(
        .NUM_SOURCES (2),
        .DATA_WIDTH  (8),
        .MIN_GAP     (MIN_GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_data_bits   (in_data_bits),
        .in_data_valid  (in_data_valid),
        .in_req         (in_req),
        .out_data       (out_data),
        .out_data_bits  (out_data_bits),
        .out_data_valid (out_data_valid),
        .out_req        (out_req),
        .grant          (grant),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Producer model state.
    logic [7:0] frm [2][4];
    int         len [2];
    int         cut [2];
    int         pos [2];
    bit         active [2];
    logic [1:0] req_seen;

    exp_t sb[$];

    // Snapshot of DUT outputs taken mid-cycle.
    logic       snap_odv, snap_busy;
    logic [1:0] snap_gnt, snap_req;
    logic [7:0] snap_data;
    logic [2:0] snap_bits;

    bit gap_en;
    bit seen_hi;
    int lowcnt;
    int n_gap;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic start_frame(input int s, input int n, input int c, input logic [2:0] b,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        exp_t e;
        frm[s][0] = d0; frm[s][1] = d1; frm[s][2] = d2; frm[s][3] = d3;
        len[s] = n; cut[s] = c; pos[s] = 0; active[s] = 1'b1;
        in_data_valid[s] = 1'b1;
        in_data[s]       = d0;
        in_data_bits[s]  = b;
        for (int i = 0; i < n && i < c; i++) begin
            e.d = frm[s][i];
            e.b = b;
            e.g = (s == 0) ? 2'b01 : 2'b10;
            sb.push_back(e);
        end
    endtask

    task automatic mon();
        exp_t e;
        snap_odv  = out_data_valid;
        snap_busy = busy;
        snap_gnt  = grant;
        snap_req  = in_req;
        snap_data = out_data;
        snap_bits = out_data_bits;
        chk("req_route", in_req, out_req ? grant : 2'b00);
        if (out_data_valid && out_req) begin
            if (sb.size() == 0) chk("sb_extra", 1, 0);
            else begin
                e = sb.pop_front();
                chk("data", out_data, e.d);
                chk("bits", out_data_bits, e.b);
                chk("owner", grant, e.g);
            end
        end
        if (out_data_valid) begin
            if (gap_en && seen_hi && lowcnt > 0) begin
                chk("gap_len", lowcnt, MIN_GAP + 1);
                n_gap++;
            end
            seen_hi = 1'b1;
            lowcnt  = 0;
        end else if (seen_hi) begin
            lowcnt++;
        end
        req_seen = in_req;
    endtask

    task automatic drv();
        for (int s = 0; s < 2; s++) begin
            if (active[s] && req_seen[s]) begin
                pos[s]++;
                if (pos[s] >= len[s] || pos[s] >= cut[s]) begin
                    active[s]        = 1'b0;
                    in_data_valid[s] = 1'b0;
                    in_data[s]       = 8'h00;
                end else begin
                    in_data[s] = frm[s][pos[s]];
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        drv();
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        tick();
        while ((active[0] || active[1] || snap_busy) && k < bound) begin
            tick();
            k++;
        end
        chk("idle_timeout", k < bound, 1);
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic arm_gap();
        gap_en  = 1'b1;
        seen_hi = 1'b0;
        lowcnt  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; out_req = 1'b1;
        in_data = '0; in_data_bits = '0; in_data_valid = '0;
        active[0] = 1'b0; active[1] = 1'b0; req_seen = '0;
        gap_en = 1'b0; seen_hi = 1'b0; lowcnt = 0; n_gap = 0;
        repeat (3) tick();
        chk("rst_grant", snap_gnt, 0);
        chk("rst_odv", snap_odv, 0);
        chk("rst_busy", snap_busy, 0);
        chk("rst_data", snap_data, 0);
        chk("rst_bits", snap_bits, 0);
        chk("rst_req", snap_req, 0);
        rst = 1'b0;
        tick();

        // Single source, latency and pass-through.
        start_frame(0, 3, 3, 3'd3, 8'hA5, 8'h5A, 8'hFF, 8'h00);
        tick();
        chk("lat_n", snap_odv, 0);
        tick();
        chk("lat_n1", snap_odv, 1);
        chk("lat_bits", snap_bits, 3);
        chk("lat_grant", snap_gnt, 2'b01);
        wait_idle(40);

        // Contention right after the previous owner was 0: source 1 is next... but
        // last owner was 0 only once; first make both contend with last = 0.
        // Round A: last=0 -> source 1 first, then source 0.
        arm_gap();
        start_frame(1, 2, 2, 3'd5, 8'h33, 8'h44, 8'h00, 8'h00);
        start_frame(0, 2, 2, 3'd0, 8'h11, 8'h22, 8'h00, 8'h00);
        wait_idle(60);
        // Round B: last=0 again; serve 1 alone so last=1, then contend -> 0 first.
        gap_en = 1'b0;
        start_frame(1, 1, 1, 3'd1, 8'h55, 8'h00, 8'h00, 8'h00);
        wait_idle(40);
        arm_gap();
        start_frame(0, 2, 2, 3'd7, 8'h66, 8'h77, 8'h00, 8'h00);
        start_frame(1, 1, 1, 3'd2, 8'h88, 8'h00, 8'h00, 8'h00);
        wait_idle(60);

        // Abort after one byte: last=1 so source 0 owns and drops early.
        arm_gap();
        start_frame(0, 4, 1, 3'd4, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
        start_frame(1, 2, 2, 3'd6, 8'hB1, 8'hB2, 8'h00, 8'h00);
        k = 0;
        while (active[0] && k < 20) begin tick(); k++; end
        chk("abort_to", k < 20, 1);
        tick();
        chk("abort_odv", snap_odv, 0);
        chk("abort_busy", snap_busy, 1);
        tick();
        chk("gap_busy", snap_busy, 1);
        chk("gap_grant", snap_gnt, 0);
        wait_idle(60);

        // Reset during byte 2 of a frame; last=1 so source 0 owns it.
        gap_en = 1'b0;
        start_frame(0, 4, 4, 3'd3, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("mrst_grant", snap_gnt, 0);
        chk("mrst_odv", snap_odv, 0);
        chk("mrst_req", snap_req, 0);
        chk("mrst_busy", snap_busy, 0);
        in_data_valid = '0; in_data = '0;
        active[0] = 1'b0; active[1] = 1'b0;
        sb.delete();
        rst = 1'b0;
        tick();
        arm_gap();
        start_frame(0, 1, 1, 3'd1, 8'hE0, 8'h00, 8'h00, 8'h00);
        start_frame(1, 1, 1, 3'd2, 8'hE1, 8'h00, 8'h00, 8'h00);
        wait_idle(60);

        // out_req pulses in IDLE and GAP never reach a producer.
        gap_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            out_req = i[0];
            tick();
            chk("idle_req", snap_req, 0);
        end
        out_req = 1'b1;
        start_frame(1, 1, 1, 3'd0, 8'hF0, 8'h00, 8'h00, 8'h00);
        k = 0;
        while (active[1] && k < 20) begin tick(); k++; end
        chk("f_to", k < 20, 1);
        tick();
        for (int i = 0; i < MIN_GAP; i++) begin
            out_req = (i % 2 == 0);
            tick();
            chk("gap_req", snap_req, 0);
        end
        out_req = 1'b1;
        wait_idle(40);

        chk("gap_count", n_gap, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares one downstream tx_interface (serialiser / frame encoder input) between NUM_SOURCES upstream frame producers, each driving its own tx_interface out_byte port. Arbitrates at frame granularity with round-robin priority, forwards the granted producer's byte stream and routes the downstream `req` back to that producer only. Enforces a programmable minimum idle gap between consecutive frames so the encoder always sees a clean frame end.

## Interface
- NUM_SOURCES, 2: number of upstream producers (≥2).
- DATA_WIDTH, 8: byte width, matches tx_interface DATA_WIDTH.
- MIN_GAP, 2: minimum cycles with out_data_valid low between frames (≥1).
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_SOURCES×DATA_WIDTH  per-source byte.
- in_data_bits  in  NUM_SOURCES×3  per-source valid bits in first byte (0 = 8).
- in_data_valid  in  NUM_SOURCES  per-source frame in progress; high for whole frame.
- in_req  out  NUM_SOURCES  per-source byte request (only granted source ever sees 1).
- out_data  out  DATA_WIDTH  forwarded byte.
- out_data_bits  out  3  forwarded first-byte bit count.
- out_data_valid  out  1  forwarded frame valid.
- out_req  in  1  downstream byte request.
- grant  out  NUM_SOURCES  one-hot current owner, registered.
- busy  out  1  high in ACTIVE or GAP.

## Operation
- States: IDLE, ACTIVE, GAP.
- IDLE: if any in_data_valid high, pick winner round-robin starting at (last_grant+1) mod NUM_SOURCES; register grant, update last_grant, go ACTIVE. Else stay.
- ACTIVE: out_data/out_data_bits/out_data_valid = granted source's inputs (combinational mux); in_req[g] = out_req for granted g, 0 for others. When granted in_data_valid is low: go GAP, load gap counter with MIN_GAP-1, clear grant.
- GAP: outputs idle; counter decrements; at 0 go IDLE. Requests arriving during GAP are held by producers (data_valid stays high) and served from IDLE.
- data_bits not interpreted; passed through unchanged every cycle of ACTIVE.
- Non-granted producers keep data_valid high and wait; arbiter never drops them.
- Producer dropping data_valid mid-frame = frame end (abort handled downstream); treated identically to normal end.
- out_req while not ACTIVE is ignored (not routed anywhere).

## Timing
- Reset values: state IDLE, grant 0, last_grant NUM_SOURCES-1 (source 0 wins first), gap counter 0, busy 0; out_data 0, out_data_bits 0, out_data_valid 0, all in_req 0.
- Grant latency: in_data_valid high in IDLE at edge N → grant and out_data_valid high after edge N (cycle N+1).
- Forwarding in ACTIVE is zero-latency: out_req→in_req and in_data→out_data same cycle.
- Frame end: granted in_data_valid low at cycle M → out_data_valid low in cycle M; total low time before next frame's out_data_valid = MIN_GAP + 1 cycles (M, GAP cycles, IDLE arbitration cycle).
- Simultaneous valid on several sources in IDLE: exactly one grant, round-robin order.
- Reset mid-frame: next cycle all outputs at reset values, no in_req pulse.

## Structure
- tx_arbiter_pkg: state enum (IDLE, ACTIVE, GAP) and gap counter width function ($clog2(MIN_GAP)+1).
- Sub-module rr_picker: combinational round-robin one-hot select from request vector and last-grant index.

## Test plan
- Single source 0 sends 3 bytes 0xA5,0x5A,0xFF with data_bits=3 → out_data_valid rises 1 cycle after in_data_valid, out_data_bits=3, bytes appear in order, in_req[1] never high.
- Sources 0 and 1 assert valid same cycle after reset → source 0 framed first, then ≥MIN_GAP+1 low cycles, then source 1; next contention grants source 1 ... alternating.
- MIN_GAP=4, source 1 waiting while source 0 ends → out_data_valid low exactly 5 cycles between frames.
- Granted source drops valid after 1 of 4 bytes → out_data_valid low same cycle, state GAP, other source then granted.
- Assert rst during byte 2 of a frame → next cycle grant=0, out_data_valid=0, all in_req 0; after release source 0 regains grant first.
- out_req pulses during IDLE/GAP → no in_req asserted on any source.
